// File: rtl/kbd_pkg.sv
// Shared types and scan-code decode for the PS/2 to Spectrum matrix keyboard.
package kbd_pkg;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_DATA,
        RX_PARITY,
        RX_STOP
    } rx_state_t;

    localparam logic [7:0] SC_REL  = 8'hF0;
    localparam logic [7:0] SC_EXT  = 8'hE0;
    localparam logic [7:0] SC_BKSP = 8'h66;
    localparam logic [7:0] SC_F1   = 8'h05;
    localparam logic [7:0] SC_F11  = 8'h78;

    // Returns {hit, row[2:0], bit[2:0]}; hit=0 for codes with no matrix position.
    function automatic logic [6:0] map_code(input logic [7:0] code, input logic ext);
        logic [6:0] res;
        res = '0;
        if (ext) begin
            case (code)
                8'h5A:   res = {1'b1, 3'd6, 3'd0};
                8'h14:   res = {1'b1, 3'd7, 3'd1};
                default: res = '0;
            endcase
        end else begin
            case (code)
                8'h12, 8'h59: res = {1'b1, 3'd0, 3'd0};
                8'h1A:   res = {1'b1, 3'd0, 3'd1};
                8'h22:   res = {1'b1, 3'd0, 3'd2};
                8'h21:   res = {1'b1, 3'd0, 3'd3};
                8'h2A:   res = {1'b1, 3'd0, 3'd4};
                8'h1C:   res = {1'b1, 3'd1, 3'd0};
                8'h1B:   res = {1'b1, 3'd1, 3'd1};
                8'h23:   res = {1'b1, 3'd1, 3'd2};
                8'h2B:   res = {1'b1, 3'd1, 3'd3};
                8'h34:   res = {1'b1, 3'd1, 3'd4};
                8'h15:   res = {1'b1, 3'd2, 3'd0};
                8'h1D:   res = {1'b1, 3'd2, 3'd1};
                8'h24:   res = {1'b1, 3'd2, 3'd2};
                8'h2D:   res = {1'b1, 3'd2, 3'd3};
                8'h2C:   res = {1'b1, 3'd2, 3'd4};
                8'h16:   res = {1'b1, 3'd3, 3'd0};
                8'h1E:   res = {1'b1, 3'd3, 3'd1};
                8'h26:   res = {1'b1, 3'd3, 3'd2};
                8'h25:   res = {1'b1, 3'd3, 3'd3};
                8'h2E:   res = {1'b1, 3'd3, 3'd4};
                8'h45:   res = {1'b1, 3'd4, 3'd0};
                8'h46:   res = {1'b1, 3'd4, 3'd1};
                8'h3E:   res = {1'b1, 3'd4, 3'd2};
                8'h3D:   res = {1'b1, 3'd4, 3'd3};
                8'h36:   res = {1'b1, 3'd4, 3'd4};
                8'h4D:   res = {1'b1, 3'd5, 3'd0};
                8'h44:   res = {1'b1, 3'd5, 3'd1};
                8'h43:   res = {1'b1, 3'd5, 3'd2};
                8'h3C:   res = {1'b1, 3'd5, 3'd3};
                8'h35:   res = {1'b1, 3'd5, 3'd4};
                8'h5A:   res = {1'b1, 3'd6, 3'd0};
                8'h4B:   res = {1'b1, 3'd6, 3'd1};
                8'h42:   res = {1'b1, 3'd6, 3'd2};
                8'h3B:   res = {1'b1, 3'd6, 3'd3};
                8'h33:   res = {1'b1, 3'd6, 3'd4};
                8'h29:   res = {1'b1, 3'd7, 3'd0};
                8'h14:   res = {1'b1, 3'd7, 3'd1};
                8'h3A:   res = {1'b1, 3'd7, 3'd2};
                8'h31:   res = {1'b1, 3'd7, 3'd3};
                8'h32:   res = {1'b1, 3'd7, 3'd4};
                default: res = '0;
            endcase
        end
        return res;
    endfunction

endpackage

// File: rtl/ps2_rx.sv
// PS/2 device-to-host frame receiver: pad synchroniser, falling-edge detect,
// frame FSM with odd-parity/stop check and a mid-frame idle timeout.
//
// state     | meaning
// RX_IDLE   | waiting for a start bit (data=0 on a falling edge)
// RX_DATA   | shifting in 8 data bits, LSB first
// RX_PARITY | capturing the parity bit
// RX_STOP   | checking stop bit and parity, emitting the byte if good
module ps2_rx
    import kbd_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 14000,
    parameter int SYNC_STAGES    = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic       rx_valid,
    output logic [7:0] rx_byte
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TIMER_LOAD = TW'(TIMEOUT_CYCLES - 1);

    logic [SYNC_STAGES-1:0] clk_sync;
    logic [SYNC_STAGES-1:0] data_sync;
    logic                   clk_prev;
    logic                   clk_s;
    logic                   data_s;
    logic                   fall;

    logic [TW-1:0] timer_q;
    logic          timeout;

    rx_state_t  state_q, state_d;
    logic [7:0] shift_q, shift_d;
    logic [2:0] cnt_q, cnt_d;
    logic       par_q, par_d;
    logic       valid_d;
    logic [7:0] byte_q, byte_d;

    assign clk_s   = clk_sync[SYNC_STAGES-1];
    assign data_s  = data_sync[SYNC_STAGES-1];
    assign fall    = clk_prev & ~clk_s;
    assign timeout = (timer_q == '0);

    // Lines idle high, so the synchroniser resets to 1 to avoid a false edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            clk_sync  <= '1;
            data_sync <= '1;
            clk_prev  <= 1'b1;
        end else begin
            clk_sync  <= {clk_sync[SYNC_STAGES-2:0], ps2_clk};
            data_sync <= {data_sync[SYNC_STAGES-2:0], ps2_data};
            clk_prev  <= clk_s;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || fall) begin
            timer_q <= TIMER_LOAD;
        end else if (!timeout) begin
            timer_q <= timer_q - TW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= RX_IDLE;
            shift_q  <= '0;
            cnt_q    <= '0;
            par_q    <= 1'b0;
            rx_valid <= 1'b0;
            byte_q   <= '0;
        end else begin
            state_q  <= state_d;
            shift_q  <= shift_d;
            cnt_q    <= cnt_d;
            par_q    <= par_d;
            rx_valid <= valid_d;
            byte_q   <= byte_d;
        end
    end

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        cnt_d   = cnt_q;
        par_d   = par_q;
        valid_d = 1'b0;
        byte_d  = byte_q;
        if (timeout && state_q != RX_IDLE) begin
            state_d = RX_IDLE;
        end else if (fall) begin
            case (state_q)
                RX_IDLE: begin
                    if (!data_s) begin
                        state_d = RX_DATA;
                        cnt_d   = '0;
                    end
                end
                RX_DATA: begin
                    shift_d = {data_s, shift_q[7:1]};
                    cnt_d   = cnt_q + 3'd1;
                    if (cnt_q == 3'd7) begin
                        state_d = RX_PARITY;
                    end
                end
                RX_PARITY: begin
                    par_d   = data_s;
                    state_d = RX_STOP;
                end
                RX_STOP: begin
                    if (data_s && ((^shift_q) ^ par_q)) begin
                        valid_d = 1'b1;
                        byte_d  = shift_q;
                    end
                    state_d = RX_IDLE;
                end
                default: state_d = RX_IDLE;
            endcase
        end
    end

    assign rx_byte = byte_q;

endmodule

// File: rtl/ps2_matrix_kbd.sv
// PS/2 keyboard to ZX Spectrum 8x5 key matrix; answers ULA port 0xFE reads
// with active-low column bits for the rows selected by A[15:8].
module ps2_matrix_kbd
    import kbd_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 14000,
    parameter int SYNC_STAGES    = 2
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        PS2_CLK,
    input  logic        PS2_DATA,
    input  logic [15:0] A,
    output logic [4:0]  KEYB,
    output logic        F1,
    output logic        F11
);

    logic       rx_valid;
    logic [7:0] rx_byte;

    logic [7:0][4:0] key_q;
    logic [7:0][4:0] key_eff;
    logic            bksp_q;
    logic            rel_q;
    logic            ext_q;
    logic [6:0]      map;
    logic [4:0]      pressed;
    logic            unused_addr;

    assign unused_addr = ^A[7:0];

    ps2_rx #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
        .SYNC_STAGES   (SYNC_STAGES)
    ) u_rx (
        .clk     (CLK),
        .reset   (RESET),
        .ps2_clk (PS2_CLK),
        .ps2_data(PS2_DATA),
        .rx_valid(rx_valid),
        .rx_byte (rx_byte)
    );

    assign map = map_code(rx_byte, ext_q);

    always_ff @(posedge CLK) begin
        if (RESET) begin
            key_q  <= '0;
            bksp_q <= 1'b0;
            rel_q  <= 1'b0;
            ext_q  <= 1'b0;
            F1     <= 1'b0;
            F11    <= 1'b0;
        end else if (rx_valid) begin
            if (rx_byte == SC_REL) begin
                rel_q <= 1'b1;
            end else if (rx_byte == SC_EXT) begin
                ext_q <= 1'b1;
            end else begin
                rel_q <= 1'b0;
                ext_q <= 1'b0;
                if (!ext_q && rx_byte == SC_BKSP) begin
                    bksp_q <= ~rel_q;
                end else if (!ext_q && rx_byte == SC_F1) begin
                    F1 <= ~rel_q;
                end else if (!ext_q && rx_byte == SC_F11) begin
                    F11 <= ~rel_q;
                end else if (map[6]) begin
                    key_q[map[5:3]][map[2:0]] <= ~rel_q;
                end
            end
        end
    end

    // Backspace is CAPS+0 layered on top, so it never releases a held CAPS or 0.
    always_comb begin
        key_eff       = key_q;
        key_eff[0][0] = key_q[0][0] | bksp_q;
        key_eff[4][0] = key_q[4][0] | bksp_q;
    end

    always_comb begin
        pressed = '0;
        for (int r = 0; r < 8; r++) begin
            if (!A[8+r]) begin
                pressed = pressed | key_eff[r];
            end
        end
        KEYB = ~pressed;
    end

endmodule

// File: doc/ps2_matrix_kbd.md
Name: ps2_matrix_kbd

Overview:
- Converts a PS/2 keyboard byte stream into the 8x5 ZX Spectrum key matrix.
- Answers ULA port 0xFE reads with active-low column bits selected by CPU address lines A[15:8].
- Sits directly upstream of the ULA read mux: it drives KEYB[4:0], which becomes ula_data[4:0]. It also drives host-hotkey levels F1/F11.
- Clocked from the 14 MHz ULA clock.

Parameters:
- TIMEOUT_CYCLES, 14000: idle cycles mid-frame before the receiver aborts (1 ms at 14 MHz).
- SYNC_STAGES, 2: synchroniser depth for PS2_CLK and PS2_DATA (minimum 2).

Ports:
- CLK  in  1  block clock (14 MHz)
- RESET  in  1  reset
- PS2_CLK  in  1  raw PS/2 clock from the pad, asynchronous
- PS2_DATA  in  1  raw PS/2 data from the pad, asynchronous
- A  in  16  CPU address bus; only A[15:8] is used for row select
- KEYB  out  5  column bits, active-low, bit0 = outermost key of the row
- F1  out  1  high while the F1 key is held
- F11  out  1  high while the F11 key is held

Interface: one clock, CLK; reset RESET is synchronous and active-high.

Behaviour:
- Reset state: all 40 matrix bits released, backspace flag clear, receiver in IDLE, release and extended flags clear, F1=0, F11=0. KEYB therefore reads 5'h1F for any A.
- Synchronisation: PS2_CLK and PS2_DATA each pass through SYNC_STAGES flops. A falling edge is detected when the previous synchronised PS2_CLK was 1 and the current one is 0. Data is sampled on the detect cycle.
- Receiver FSM (IDLE, DATA, PARITY, STOP). Frames are start bit 0, 8 data bits LSB first, odd parity, stop bit 1.
  - IDLE: an edge with data=0 moves to DATA. An edge with data=1 is ignored.
  - DATA: shifts in 8 bits via a 3-bit counter, then moves to PARITY.
  - PARITY: stores the parity bit, then moves to STOP.
  - STOP: on the edge, if stop=1 and the XOR of the 8 data bits plus parity is 1, pulse rx_valid for exactly 1 cycle on the following cycle with rx_byte. Otherwise discard the frame. Both paths return to IDLE.
- Timeout: a counter clears on every edge. In any state other than IDLE, reaching TIMEOUT_CYCLES forces IDLE and drops the partial byte. No rx_valid is produced.
- Decoder, acting on each rx_valid:
  - 0xF0 sets release.
  - 0xE0 sets ext.
  - Any other byte performs the make/break (make if release=0, break if release=1), then clears both flags.
  - Unmapped codes, including 0xAA and 0xFA, only clear the flags.
- Decoder update timing: the matrix updates on the cycle after rx_valid. KEYB reflects a key 2 cycles after the stop-bit edge detect.
- Non-extended map (row = A-line index minus 8, bit):
  - Row 0: 12/59 CAPS b0, 1A Z b1, 22 X b2, 21 C b3, 2A V b4.
  - Row 1: 1C A, 1B S, 23 D, 2B F, 34 G.
  - Row 2: 15 Q, 1D W, 24 E, 2D R, 2C T.
  - Row 3: 16 1, 1E 2, 26 3, 25 4, 2E 5.
  - Row 4: 45 0, 46 9, 3E 8, 3D 7, 36 6.
  - Row 5: 4D P, 44 O, 43 I, 3C U, 35 Y.
  - Row 6: 5A ENTER, 4B L, 42 K, 3B J, 33 H.
  - Row 7: 29 SPACE, 14 SYM, 3A M, 31 N, 32 B.
- Special codes:
  - 66 (backspace) sets or clears a separate bksp flag. The CAPS bit output is caps|bksp, and row 4 bit0 output is zero|bksp. Releasing backspace never clears a physically held CAPS or 0.
  - 05 drives F1 and 78 drives F11, make=1 and break=0. These do not touch the matrix.
- Extended map: E0 5A gives ENTER and E0 14 gives SYM. All other extended codes are ignored.
- Repeated make of a held key: no change (typematic repeat is harmless).
- KEYB is combinational from A and the matrix registers. For each bit b, KEYB[b] = ~OR over r of (A[8+r]==0 & key[r][b]). Multiple low A lines combine rows. A[15:8]=8'hFF gives 5'h1F.
- RESET mid-frame: the receiver drops the frame and the matrix clears in the same cycle.

Decomposition:
- Shared package kbd_pkg holds:
  - the rx state enum;
  - scan-code constants (SC_REL=8'hF0, SC_EXT=8'hE0, SC_BKSP, SC_F1, SC_F11);
  - a function that maps a scan code plus ext flag to {hit, row[2:0], bit[2:0]}.
- One sub-module, ps2_rx, covers the synchroniser, edge detect, FSM, parity check and timeout. It outputs rx_valid and rx_byte[7:0].

Test Plan:
- Frame 1C with A=16'hFDFE: KEYB=5'h1E two cycles after the stop edge. Then frames F0 1C: KEYB=5'h1F.
- Frame 66 with A=16'hFEFE: KEYB=5'h1E. With A=16'hEFFE: KEYB=5'h1E. Frames 12, then F0 66: CAPS stays pressed (row 0 read = 5'h1E) and row 4 read = 5'h1F.
- Frame 1C sent with bad parity, or with stop=0: no rx_valid and KEYB unchanged at 5'h1F. A following good frame decodes normally.
- Send start plus 3 data bits, then hold PS2_CLK high for TIMEOUT_CYCLES: FSM returns to IDLE. A next full frame 29 gives KEYB=5'h1E with A=16'h7FFE.
- Press 1C and 15, then read A=16'hF9FE (rows 1 and 2 low): KEYB=5'h1E. Assert RESET for 1 cycle: KEYB=5'h1F and F1=F11=0.
- Frames 05 → F1=1. Frames F0 05 → F1=0. Frames E0 5A → row 6 bit0 low. Frames E0 75 → no matrix change.
